// File: rtl/pipe_stage_reg.sv
// Reusable pipeline boundary register: valid/ctrl/data with stall, flush and multi-cycle hold.
// Optional performance counters are compiled in when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 128,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                HOLD_CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  hold_req_i,
  input  logic [HOLD_CNT_W-1:0] hold_cycles_i,
  input  logic                  valid_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [DATA_W-1:0]     data_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]           bubble_cnt_o,
  output logic [31:0]           hold_cnt_o,
`endif
  output logic                  valid_o,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  busy_o
);

  logic                  valid_reg;
  logic [CTRL_W-1:0]     ctrl_reg;
  logic [DATA_W-1:0]     data_reg;
  logic [HOLD_CNT_W-1:0] cnt_reg;
  logic [HOLD_CNT_W-1:0] cnt_next;
  logic [HOLD_CNT_W-1:0] cnt_dec;
  logic [HOLD_CNT_W-1:0] req_remaining;
  logic                  req_valid;
  logic                  hold_active;

  // A request for zero cycles is a no-op, so it never contributes to the hold.
  assign req_valid     = hold_req_i && (hold_cycles_i != '0);
  assign req_remaining = hold_cycles_i - 1'b1;
  assign cnt_dec       = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
  assign hold_active   = stall_i || (cnt_reg != '0) || req_valid;

  // A new request can only lengthen the remaining hold, never shorten it.
  always_comb begin
    cnt_next = cnt_dec;
    if (flush_i) begin
      cnt_next = '0;
    end else if (req_valid && (req_remaining > cnt_dec)) begin
      cnt_next = req_remaining;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= CTRL_BUBBLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (flush_i) begin
        valid_reg <= 1'b0;
        ctrl_reg  <= CTRL_BUBBLE;
        data_reg  <= '0;
      end else if (!hold_active) begin
        valid_reg <= valid_i;
        ctrl_reg  <= ctrl_i;
        data_reg  <= data_i;
      end
    end
  end

  assign valid_o = valid_reg;
  assign ctrl_o  = ctrl_reg;
  assign data_o  = data_reg;
  assign busy_o  = (cnt_reg != '0);

`ifdef PIPE_STAGE_PERF_EN
  // Index 0 counts flush (bubble) edges, index 1 counts held edges; a flush edge is never a hold.
  logic [1:0] perf_inc;
  assign perf_inc = {hold_active && !flush_i, flush_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] count_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= '0;
        end else if (perf_inc[gi] && (count_reg != 32'hFFFF_FFFF)) begin
          count_reg <= count_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign bubble_cnt_o = g_perf[0].count_reg;
  assign hold_cnt_o   = g_perf[1].count_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_pipe_stage_reg;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;
  localparam int HCW    = 3;
  localparam logic [CTRL_W-1:0] BUBBLE = 16'h0013;

  logic              clk = 1'b0;
  logic              rst, flush_i, stall_i, hold_req_i, valid_i;
  logic [HCW-1:0]    hold_cycles_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o, busy_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       bubble_cnt_o, hold_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  int                m_remaining;   // edges still to hold after the current one
  longint            m_bubbles, m_holds;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUBBLE), .HOLD_CNT_W(HCW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .hold_req_i(hold_req_i), .hold_cycles_i(hold_cycles_i),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
`ifdef PIPE_STAGE_PERF_EN
    .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o),
`endif
    .valid_o(valid_o), .ctrl_o(ctrl_o), .data_o(data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    rst = 0; flush_i = 0; stall_i = 0; hold_req_i = 0; hold_cycles_i = '0;
    valid_i = 0; ctrl_i = '0; data_i = '0;
  endtask

  // Advance one edge; the model follows the priority rules rst > flush > hold > load.
  task automatic tick();
    int  n;
    bit  held;
    @(posedge clk);
    n = int'(hold_cycles_i);
    if (rst) begin
      m_valid = 0; m_ctrl = BUBBLE; m_data = '0; m_remaining = 0;
      m_bubbles = 0; m_holds = 0;
    end else if (flush_i) begin
      m_valid = 0; m_ctrl = BUBBLE; m_data = '0; m_remaining = 0;
      m_bubbles++;
    end else begin
      held = stall_i || (m_remaining > 0) || (hold_req_i && n > 0);
      if (m_remaining > 0) m_remaining--;
      if (hold_req_i && n > 0 && n - 1 > m_remaining) m_remaining = n - 1;
      if (held) m_holds++;
      else begin m_valid = valid_i; m_ctrl = ctrl_i; m_data = data_i; end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; valid_i = 1; ctrl_i = 16'hFFFF; data_i = '1;
    tick(); tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
    checks++; if (ctrl_o !== BUBBLE) begin errors++; $display("FAIL reset_ctrl got %0h exp %0h", ctrl_o, BUBBLE); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy_o); end
    rst = 0; valid_i = 1; ctrl_i = 16'h00A5; data_i = 128'h1234;
    tick();
    checks++; if (ctrl_o !== 16'h00A5) begin errors++; $display("FAIL load_ctrl got %0h exp 00a5", ctrl_o); end
    checks++; if (data_o !== 128'h1234) begin errors++; $display("FAIL load_data got %0h exp 1234", data_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL load_valid got %0h exp 1", valid_o); end
  endtask

  task automatic test_stall_flush();
    valid_i = 1; ctrl_i = 16'h0011; data_i = 128'h11;
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      ctrl_i = 16'h0100 + 16'(i); data_i = 128'(i + 77);
      tick();
      checks++; if (ctrl_o !== 16'h0011) begin errors++; $display("FAIL stall_ctrl[%0d] got %0h exp 0011", i, ctrl_o); end
      checks++; if (data_o !== 128'h11) begin errors++; $display("FAIL stall_data[%0d] got %0h exp 11", i, data_o); end
    end
    flush_i = 1;
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_flush_valid got %0h exp 0", valid_o); end
    checks++; if (ctrl_o !== BUBBLE) begin errors++; $display("FAIL stall_flush_ctrl got %0h exp %0h", ctrl_o, BUBBLE); end
    idle_inputs();
  endtask

  task automatic test_multi_hold();
    logic [4:0] busy_seq;
    valid_i = 1; ctrl_i = 16'h0AAA; data_i = 128'hA;
    tick();
    ctrl_i = 16'h0BBB; data_i = 128'hB; hold_req_i = 1; hold_cycles_i = 3'd3;
    for (int e = 1; e <= 4; e++) begin
      tick();
      hold_req_i = 0;
      busy_seq[e] = busy_o;
      if (e <= 3) begin
        checks++; if (data_o !== 128'hA) begin errors++; $display("FAIL hold3_frozen[%0d] got %0h exp a", e, data_o); end
      end
    end
    checks++; if (data_o !== 128'hB) begin errors++; $display("FAIL hold3_release got %0h exp b", data_o); end
    checks++; if (busy_seq[4:1] !== 4'b0011) begin errors++; $display("FAIL hold3_busy_seq got %b exp 0011", busy_seq[4:1]); end
    idle_inputs();
  endtask

  task automatic test_hold_extend();
    int n_busy;
    hold_req_i = 1; hold_cycles_i = 3'd3; valid_i = 1; data_i = 128'h55;
    tick();
    hold_cycles_i = 3'd1;              // remaining 2 -> must go 1, 0 (not shortened)
    tick();
    hold_req_i = 0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL extend_short_busy got %0h exp 1", busy_o); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL extend_short_end got %0h exp 0", busy_o); end
    checks++; if (data_o === 128'h55) begin errors++; $display("FAIL extend_short_loaded_early got %0h exp held", data_o); end
    hold_req_i = 1; hold_cycles_i = 3'd2;
    tick();
    hold_cycles_i = 3'd5;              // lengthen to 4 remaining
    tick();
    hold_req_i = 0;
    n_busy = 0;
    for (int i = 0; i < 8 && busy_o; i++) begin n_busy++; tick(); end
    checks++; if (n_busy != 4) begin errors++; $display("FAIL extend_long_busy_edges got %0d exp 4", n_busy); end
    checks++; if (data_o !== m_data) begin errors++; $display("FAIL extend_long_data got %0h exp %0h", data_o, m_data); end
    hold_req_i = 1; hold_cycles_i = 3'd0; data_i = 128'h77;
    tick();
    checks++; if (data_o !== 128'h77) begin errors++; $display("FAIL zero_req_load got %0h exp 77", data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_req_busy got %0h exp 0", busy_o); end
    idle_inputs();
  endtask

  task automatic test_abort_mid_hold(input bit use_rst);
    valid_i = 1; ctrl_i = 16'h0CCC; data_i = 128'hC;
    tick();
    hold_req_i = 1; hold_cycles_i = 3'd6;
    tick();
    hold_req_i = 0;
    if (use_rst) rst = 1; else flush_i = 1;
    tick();
    rst = 0; flush_i = 0; valid_i = 0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL abort%0d_valid got %0h exp 0", use_rst, valid_o); end
    checks++; if (ctrl_o !== BUBBLE) begin errors++; $display("FAIL abort%0d_ctrl got %0h exp %0h", use_rst, ctrl_o, BUBBLE); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL abort%0d_data got %0h exp 0", use_rst, data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort%0d_busy got %0h exp 0", use_rst, busy_o); end
    data_i = 128'hD;
    tick();
    checks++; if (data_o !== 128'hD) begin errors++; $display("FAIL abort%0d_reload got %0h exp d", use_rst, data_o); end
    idle_inputs();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin flush_i = 1; stall_i = (i == 1); tick(); end
    flush_i = 0; stall_i = 1;
    for (int i = 0; i < 7; i++) tick();
    stall_i = 0; tick();
    checks++; if (bubble_cnt_o !== 32'd4) begin errors++; $display("FAIL perf_bubbles got %0d exp 4", bubble_cnt_o); end
    checks++; if (hold_cnt_o !== 32'd7) begin errors++; $display("FAIL perf_holds got %0d exp 7", hold_cnt_o); end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      stall_i       = ($urandom_range(0, 5) == 0);
      hold_req_i    = ($urandom_range(0, 7) == 0);
      hold_cycles_i = HCW'($urandom);
      valid_i       = 1'($urandom);
      ctrl_i        = CTRL_W'($urandom);
      data_i        = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (valid_o !== m_valid || ctrl_o !== m_ctrl || data_o !== m_data || busy_o !== (m_remaining > 0)) begin
        errors++;
        $display("FAIL random[%0d] got v=%0h c=%0h d=%0h b=%0h exp v=%0h c=%0h d=%0h b=%0h",
                 i, valid_o, ctrl_o, data_o, busy_o, m_valid, m_ctrl, m_data, m_remaining > 0);
      end
`ifdef PIPE_STAGE_PERF_EN
      checks++;
      if (bubble_cnt_o !== 32'(m_bubbles) || hold_cnt_o !== 32'(m_holds)) begin
        errors++;
        $display("FAIL random_perf[%0d] got %0d/%0d exp %0d/%0d", i, bubble_cnt_o, hold_cnt_o, m_bubbles, m_holds);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    m_valid = 0; m_ctrl = BUBBLE; m_data = '0; m_remaining = 0; m_bubbles = 0; m_holds = 0;
    test_reset();
    test_stall_flush();
    test_multi_hold();
    test_hold_extend();
    test_abort_mid_hold(1'b0);
    test_abort_mid_hold(1'b1);
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
